add_serial_nib: RTL



---
 rtl/add_serial_nib_pkg.sv | 16 +
 rtl/add_serial_nib_add4.sv | 30 +++
 rtl/add_serial_nib.sv | 124 ++++++++++++
 3 files changed

// File: rtl/add_serial_nib_pkg.sv
// Shared ALU definitions for the nibble-serial adder: FSM states, slice width
// and the add/subtract op encoding.
package add_serial_nib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_serial_nib_add4.sv
// 4-bit carry-lookahead adder slice (ADD_4); the single slice the serial
// adder reuses once per nibble.
module add_serial_nib_add4 (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] res,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign res  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/add_serial_nib.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one ADD_4 slice.
// state | meaning
// IDLE  | ready for operands; previous result held on res/cout/ovf/zero
// RUN   | one nibble per cycle through the slice, LSB nibble first
// DONE  | result presented with out_valid until out_ready
module add_serial_nib
    import add_serial_nib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = $clog2(NIB);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   b_eff;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               sign_a;
    logic               sign_b;
    logic               last;
    logic [NIB_W-1:0]   slice_sum;
    logic               slice_cout;

    add_serial_nib_add4 u_add4 (
        .cin  (carry),
        .a    (opa[NIB_W-1:0]),
        .b    (opb[NIB_W-1:0]),
        .res  (slice_sum),
        .cout (slice_cout)
    );

    assign b_eff   = (op_sub == OP_SUB) ? ~b : b;
    assign last    = (cnt == CNT_W'(NIB - 1));
    assign acc_nxt = {slice_sum, acc[WIDTH-1:NIB_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result registers load only on the final nibble, so a partial sum never
    // reaches res and the last result survives through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            res    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa    <= a;
                        opb    <= b_eff;
                        carry  <= (op_sub == OP_SUB);
                        cnt    <= '0;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b_eff[WIDTH-1];
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    opa   <= opa >> NIB_W;
                    opb   <= opb >> NIB_W;
                    carry <= slice_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        res  <= acc_nxt;
                        cout <= slice_cout;
                        zero <= (acc_nxt == '0);
                        ovf  <= (sign_a == sign_b) && (acc_nxt[WIDTH-1] != sign_a);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
